port_wr_sram_scanner: RTL and testbench
=======================================

Name: port_wr_sram_scanner

Overview:
- Backend partner of the per-port write-side SRAM matcher; one instance per input port.
- Rotates a candidate SRAM index and presents that SRAM's registered status (accessible, free space, packet count for the new packet's destination) to the matcher, one SRAM per cycle.
- On the matcher's success pulse, claims the chosen SRAM from the global SRAM allocator through a req/gnt handshake.
- Holds the binding until the front end releases it.

Parameters:
- SRAM_NUM, 32, number of SRAMs scanned.
- IDX_W, 5, SRAM index width; "none" sentinel = SRAM_NUM, carried on IDX_W+1 bits.
- SPACE_W, 11, free-space width (half-words).
- AMOUNT_W, 9, per-port packet-count width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_offset  in  IDX_W  first index scanned, per-port stagger.
- match_enable  in  1  front end requests a match; same signal that feeds the matcher.
- match_suc  in  1  one-cycle success pulse from the matcher.
- match_best_sram  in  IDX_W+1  matcher's chosen SRAM, valid with match_suc.
- sram_accessible  in  SRAM_NUM  per-SRAM "not occupied" flags.
- sram_free_space  in  SRAM_NUM*SPACE_W  flattened; SRAM i at bits [i*SPACE_W +: SPACE_W].
- sram_packet_amount  in  SRAM_NUM*AMOUNT_W  flattened; per-SRAM count for the current destination port.
- match_sram  out  IDX_W  index of the presented SRAM.
- accessible  out  1  presented SRAM usable; forced 0 outside SCAN.
- free_space  out  SPACE_W  presented SRAM free space.
- packet_amount  out  AMOUNT_W  presented SRAM packet count.
- claim_req  out  1  claim request to the allocator.
- claim_sram  out  IDX_W  SRAM being claimed.
- claim_gnt  in  1  allocator grant, one-cycle pulse.
- bound_valid  out  1  port holds a claimed SRAM.
- bound_sram  out  IDX_W+1  claimed SRAM; SRAM_NUM when none.
- release  in  1  packet fully written; drop the binding.

Behaviour:
Reset values:
- State IDLE; index 0; match_sram 0; accessible 0; free_space 0; packet_amount 0.
- claim_req 0; claim_sram 0; bound_valid 0; bound_sram = SRAM_NUM.
- Reset is asynchronous: asserting rst_n low mid-operation (including during CLAIM) returns all outputs to these values immediately. claim_req drops without waiting for claim_gnt.

States: IDLE, SCAN, CLAIM, BOUND.

IDLE:
- accessible = 0.
- match_enable=1 → SCAN; index <= scan_offset.

SCAN:
- Each cycle, match_sram/accessible/free_space/packet_amount <= the status of SRAM[index], all sampled in the same cycle. Outputs therefore lag the index by 1 cycle, and the four fields are always mutually consistent.
- index <= (index == SRAM_NUM-1) ? 0 : index+1. The wrap is explicit, so non-power-of-2 SRAM_NUM is legal.
- match_enable=0 → IDLE; accessible <= 0 on the same edge.
- match_suc=1 with match_best_sram < SRAM_NUM → CLAIM; claim_req <= 1; claim_sram <= match_best_sram[IDX_W-1:0]; accessible <= 0.
- match_suc=1 with match_best_sram >= SRAM_NUM → IDLE (illegal pick, discarded).
- match_suc takes priority over match_enable=0 in the same cycle.

CLAIM:
- claim_req and claim_sram are held stable until claim_gnt.
- claim_gnt=1 → BOUND; claim_req <= 0; bound_valid <= 1; bound_sram <= claim_sram.
- claim_gnt is honoured even if match_enable dropped meanwhile.

BOUND:
- Scanning is stopped; accessible = 0.
- release=1 → IDLE; bound_valid <= 0; bound_sram <= SRAM_NUM.
- match_enable is ignored in BOUND.

Ignored inputs:
- release outside BOUND.
- claim_gnt outside CLAIM.
- match_suc outside SCAN.

Latency:
- match_enable rise → first valid presentation is 2 edges later: one edge for IDLE→SCAN, one for the sample.
- match_suc → claim_req is 1 edge.
- claim_gnt → bound_valid is 1 edge.

Optional Feature:
CLAIM_TIMEOUT_EN
- Defined: a 4-bit counter runs in CLAIM. If 16 cycles pass without claim_gnt:
  - claim_req <= 0.
  - claim_fail (extra output, 1 bit, one-cycle pulse) is asserted.
  - Return to SCAN when match_enable=1, otherwise to IDLE.
  - index resumes from claim_sram+1 (with wrap).
- Undefined: claim_fail does not exist; CLAIM waits indefinitely for claim_gnt.

Test Plan:
- Reset, then match_enable=1 with scan_offset=30, SRAM_NUM=32 → match_sram sequence 30,31,0,1 on consecutive cycles starting 2 edges after enable; free_space/packet_amount match the slice of the presented index.
- sram_accessible=0x0000_0004, SRAM2 free_space=100, packet_amount=7 → at match_sram=2 the outputs read accessible=1, free_space=100, packet_amount=7; all other indices read accessible=0.
- match_suc with match_best_sram=9 → next edge claim_req=1, claim_sram=9, accessible=0; claim_gnt 3 cycles later → bound_valid=1, bound_sram=9, claim_req=0; release → bound_sram=32.
- match_suc and match_enable=0 in the same cycle → CLAIM entered. Separately, match_suc with match_best_sram=32 → IDLE and no claim_req.
- rst_n pulled low during CLAIM, asynchronously between clock edges → claim_req=0 and bound_sram=32 before the next clk edge.
- With CLAIM_TIMEOUT_EN, no grant → claim_fail pulses after 16 cycles in CLAIM; match_sram resumes at claim_sram+1.

Source files
------------

// File: rtl/port_wr_sram_scanner_if.sv
// Bundle between the write-side SRAM scanner and its matcher, allocator and front end.
// claim_fail exists only when CLAIM_TIMEOUT_EN is defined.
interface port_wr_sram_scanner_if #(
    parameter int unsigned SRAM_NUM = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned SPACE_W  = 11,
    parameter int unsigned AMOUNT_W = 9
) ();
    logic [IDX_W-1:0]             scan_offset;
    logic                         match_enable;
    logic                         match_suc;
    logic [IDX_W:0]               match_best_sram;
    logic [SRAM_NUM-1:0]          sram_accessible;
    logic [SRAM_NUM*SPACE_W-1:0]  sram_free_space;
    logic [SRAM_NUM*AMOUNT_W-1:0] sram_packet_amount;
    logic [IDX_W-1:0]             match_sram;
    logic                         accessible;
    logic [SPACE_W-1:0]           free_space;
    logic [AMOUNT_W-1:0]          packet_amount;
    logic                         claim_req;
    logic [IDX_W-1:0]             claim_sram;
    logic                         claim_gnt;
    logic                         bound_valid;
    logic [IDX_W:0]               bound_sram;
    // "release" is a reserved word, hence the longer name.
    logic                         release_bound;
`ifdef CLAIM_TIMEOUT_EN
    logic                         claim_fail;
`endif

    modport master (
`ifdef CLAIM_TIMEOUT_EN
        output claim_fail,
`endif
        input  scan_offset, match_enable, match_suc, match_best_sram,
        input  sram_accessible, sram_free_space, sram_packet_amount,
        input  claim_gnt, release_bound,
        output match_sram, accessible, free_space, packet_amount,
        output claim_req, claim_sram, bound_valid, bound_sram
    );

    modport slave (
`ifdef CLAIM_TIMEOUT_EN
        input  claim_fail,
`endif
        output scan_offset, match_enable, match_suc, match_best_sram,
        output sram_accessible, sram_free_space, sram_packet_amount,
        output claim_gnt, release_bound,
        input  match_sram, accessible, free_space, packet_amount,
        input  claim_req, claim_sram, bound_valid, bound_sram
    );
endinterface

// File: rtl/port_wr_sram_scanner.sv
// Per-port write-side SRAM scanner: presents one SRAM status per cycle, claims the matcher's
// pick from the allocator and holds the binding. Optional CLAIM_TIMEOUT_EN abandons stale claims.
module port_wr_sram_scanner #(
    parameter int unsigned SRAM_NUM = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned SPACE_W  = 11,
    parameter int unsigned AMOUNT_W = 9
) (
    input logic                    clk,
    input logic                    rst_n,
    port_wr_sram_scanner_if.master bus
);
    typedef enum logic [1:0] {StIdle, StScan, StClaim, StBound} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(SRAM_NUM - 1);
    localparam logic [IDX_W:0]   NoneIdx = (IDX_W + 1)'(SRAM_NUM);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    match_sram_q, match_sram_d;
    logic                accessible_q, accessible_d;
    logic [SPACE_W-1:0]  free_space_q, free_space_d;
    logic [AMOUNT_W-1:0] packet_amount_q, packet_amount_d;
    logic                claim_req_q, claim_req_d;
    logic [IDX_W-1:0]    claim_sram_q, claim_sram_d;
    logic                bound_valid_q, bound_valid_d;
    logic [IDX_W:0]      bound_sram_q, bound_sram_d;
`ifdef CLAIM_TIMEOUT_EN
    logic [3:0]          tmo_cnt_q, tmo_cnt_d;
    logic                claim_fail_q, claim_fail_d;
`endif

    logic                sel_acc;
    logic [SPACE_W-1:0]  sel_space;
    logic [AMOUNT_W-1:0] sel_amount;
    logic [IDX_W-1:0]    idx_next;

    assign sel_acc    = bus.sram_accessible[idx_q];
    assign sel_space  = bus.sram_free_space[int'(idx_q) * SPACE_W +: SPACE_W];
    assign sel_amount = bus.sram_packet_amount[int'(idx_q) * AMOUNT_W +: AMOUNT_W];
    // Explicit wrap keeps non-power-of-2 SRAM counts legal.
    assign idx_next   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        match_sram_d    = match_sram_q;
        accessible_d    = accessible_q;
        free_space_d    = free_space_q;
        packet_amount_d = packet_amount_q;
        claim_req_d     = claim_req_q;
        claim_sram_d    = claim_sram_q;
        bound_valid_d   = bound_valid_q;
        bound_sram_d    = bound_sram_q;
`ifdef CLAIM_TIMEOUT_EN
        tmo_cnt_d       = tmo_cnt_q;
        claim_fail_d    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (bus.match_enable) begin
                    state_d = StScan;
                    idx_d   = bus.scan_offset;
                end
            end
            StScan: begin
                match_sram_d    = idx_q;
                accessible_d    = sel_acc;
                free_space_d    = sel_space;
                packet_amount_d = sel_amount;
                idx_d           = idx_next;
                if (bus.match_suc) begin
                    accessible_d = 1'b0;
                    if (bus.match_best_sram < NoneIdx) begin
                        state_d      = StClaim;
                        claim_req_d  = 1'b1;
                        claim_sram_d = bus.match_best_sram[IDX_W-1:0];
`ifdef CLAIM_TIMEOUT_EN
                        tmo_cnt_d    = '0;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!bus.match_enable) begin
                    state_d      = StIdle;
                    accessible_d = 1'b0;
                end
            end
            StClaim: begin
                if (bus.claim_gnt) begin
                    state_d       = StBound;
                    claim_req_d   = 1'b0;
                    bound_valid_d = 1'b1;
                    bound_sram_d  = {1'b0, claim_sram_q};
`ifdef CLAIM_TIMEOUT_EN
                end else if (tmo_cnt_q == 4'hF) begin
                    // Give up and resume scanning just past the SRAM we failed to get.
                    claim_req_d  = 1'b0;
                    claim_fail_d = 1'b1;
                    idx_d        = (claim_sram_q == LastIdx) ? '0 : claim_sram_q + 1'b1;
                    state_d      = bus.match_enable ? StScan : StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
`endif
                end
            end
            StBound: begin
                if (bus.release_bound) begin
                    state_d       = StIdle;
                    bound_valid_d = 1'b0;
                    bound_sram_d  = NoneIdx;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            match_sram_q    <= '0;
            accessible_q    <= 1'b0;
            free_space_q    <= '0;
            packet_amount_q <= '0;
            claim_req_q     <= 1'b0;
            claim_sram_q    <= '0;
            bound_valid_q   <= 1'b0;
            bound_sram_q    <= NoneIdx;
`ifdef CLAIM_TIMEOUT_EN
            tmo_cnt_q       <= '0;
            claim_fail_q    <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            match_sram_q    <= match_sram_d;
            accessible_q    <= accessible_d;
            free_space_q    <= free_space_d;
            packet_amount_q <= packet_amount_d;
            claim_req_q     <= claim_req_d;
            claim_sram_q    <= claim_sram_d;
            bound_valid_q   <= bound_valid_d;
            bound_sram_q    <= bound_sram_d;
`ifdef CLAIM_TIMEOUT_EN
            tmo_cnt_q       <= tmo_cnt_d;
            claim_fail_q    <= claim_fail_d;
`endif
        end
    end

    assign bus.match_sram    = match_sram_q;
    assign bus.accessible    = accessible_q;
    assign bus.free_space    = free_space_q;
    assign bus.packet_amount = packet_amount_q;
    assign bus.claim_req     = claim_req_q;
    assign bus.claim_sram    = claim_sram_q;
    assign bus.bound_valid   = bound_valid_q;
    assign bus.bound_sram    = bound_sram_q;
`ifdef CLAIM_TIMEOUT_EN
    assign bus.claim_fail    = claim_fail_q;
`endif
endmodule

// File: tb/tb_port_wr_sram_scanner.sv
// Randomized bench for port_wr_sram_scanner against a transaction-level reference model.
// Covers the CLAIM_TIMEOUT_EN build as well when that macro is defined.
module tb_port_wr_sram_scanner;
    localparam int N  = 32;
    localparam int IW = 5;
    localparam int SW = 11;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    port_wr_sram_scanner_if #(.SRAM_NUM(N), .IDX_W(IW), .SPACE_W(SW), .AMOUNT_W(AW)) bus ();

    port_wr_sram_scanner #(.SRAM_NUM(N), .IDX_W(IW), .SPACE_W(SW), .AMOUNT_W(AW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0]  acc_arr;
    logic [SW-1:0] fs_arr[N];
    logic [AW-1:0] pa_arr[N];

    // Reference model: mode 0 idle, 1 scanning, 2 claiming, 3 bound.
    // While scanning, the presented SRAM is (m_base + m_steps) mod N.
    int m_mode, m_base, m_steps, m_wait;
    int m_msram, m_acc, m_fs, m_pa, m_creq, m_csram, m_bv, m_bs, m_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pack_status();
        for (int i = 0; i < N; i++) begin
            bus.sram_accessible[i]             = acc_arr[i];
            bus.sram_free_space[i*SW +: SW]    = fs_arr[i];
            bus.sram_packet_amount[i*AW +: AW] = pa_arr[i];
        end
    endtask

    task automatic random_status();
        acc_arr = N'($urandom);
        for (int i = 0; i < N; i++) begin
            fs_arr[i] = SW'($urandom_range(0, 2047));
            pa_arr[i] = AW'($urandom_range(0, 511));
        end
        pack_status();
    endtask

    task automatic model_reset();
        m_mode = 0; m_base = 0; m_steps = 0; m_wait = 0;
        m_msram = 0; m_acc = 0; m_fs = 0; m_pa = 0;
        m_creq = 0; m_csram = 0; m_bv = 0; m_bs = N; m_fail = 0;
    endtask

    task automatic model_edge();
        int cur;
        int best;
        best   = int'(bus.match_best_sram);
        m_fail = 0;
        if (m_mode == 0) begin
            if (bus.match_enable) begin
                m_mode = 1; m_base = int'(bus.scan_offset); m_steps = 0;
            end
        end else if (m_mode == 1) begin
            cur = (m_base + m_steps) % N;
            m_steps++;
            m_msram = cur; m_acc = int'(acc_arr[cur]);
            m_fs = int'(fs_arr[cur]); m_pa = int'(pa_arr[cur]);
            if (bus.match_suc) begin
                m_acc = 0;
                if (best < N) begin
                    m_mode = 2; m_creq = 1; m_csram = best; m_wait = 0;
                end else begin
                    m_mode = 0;
                end
            end else if (!bus.match_enable) begin
                m_mode = 0; m_acc = 0;
            end
        end else if (m_mode == 2) begin
            if (bus.claim_gnt) begin
                m_mode = 3; m_creq = 0; m_bv = 1; m_bs = m_csram;
            end else begin
                m_wait++;
`ifdef CLAIM_TIMEOUT_EN
                if (m_wait == 16) begin
                    m_creq = 0; m_fail = 1;
                    m_mode = bus.match_enable ? 1 : 0;
                    m_base = m_csram + 1; m_steps = 0;
                end
`endif
            end
        end else begin
            if (bus.release_bound) begin
                m_mode = 0; m_bv = 0; m_bs = N;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("match_sram", bus.match_sram, m_msram);
        check_eq("accessible", bus.accessible, m_acc);
        check_eq("free_space", bus.free_space, m_fs);
        check_eq("packet_amount", bus.packet_amount, m_pa);
        check_eq("claim_req", bus.claim_req, m_creq);
        check_eq("claim_sram", bus.claim_sram, m_csram);
        check_eq("bound_valid", bus.bound_valid, m_bv);
        check_eq("bound_sram", bus.bound_sram, m_bs);
`ifdef CLAIM_TIMEOUT_EN
        check_eq("claim_fail", bus.claim_fail, m_fail);
`endif
    endtask

    // Advance one clock edge, then compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input bit en, input bit suc, input int best, input bit gnt, input bit rel);
        bus.match_enable    = en;
        bus.match_suc       = suc;
        bus.match_best_sram = (IW + 1)'(best);
        bus.claim_gnt       = gnt;
        bus.release_bound   = rel;
    endtask

    // Pull reset low between edges and check outputs before the next edge.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_claim_req", bus.claim_req, 0);
        check_eq("rst_bound_sram", bus.bound_sram, N);
        check_eq("rst_bound_valid", bus.bound_valid, 0);
        check_eq("rst_accessible", bus.accessible, 0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        set_in(0, 0, 0, 0, 0);
        bus.scan_offset = '0;
        random_status();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        compare_all();

        // Rotation from offset 30 with wrap, and SRAM2 as the only accessible one.
        acc_arr = 32'h0000_0004;
        fs_arr[2] = 11'd100;
        pa_arr[2] = 9'd7;
        pack_status();
        bus.scan_offset = 5'd30;
        set_in(1, 0, 0, 0, 0);
        step();
        check_eq("pre_sample_msram", bus.match_sram, 0);
        step();
        check_eq("seq0", bus.match_sram, 30);
        step();
        check_eq("seq1", bus.match_sram, 31);
        step();
        check_eq("seq2", bus.match_sram, 0);
        check_eq("seq2_acc", bus.accessible, 0);
        step();
        check_eq("seq3", bus.match_sram, 1);
        step();
        check_eq("sram2_acc", bus.accessible, 1);
        check_eq("sram2_fs", bus.free_space, 100);
        check_eq("sram2_pa", bus.packet_amount, 7);

        // Claim of SRAM9 with grant three cycles later, then release.
        set_in(1, 1, 9, 0, 0);
        step();
        check_eq("claim_req_on", bus.claim_req, 1);
        check_eq("claim_sram9", bus.claim_sram, 9);
        check_eq("claim_acc_off", bus.accessible, 0);
        set_in(1, 0, 0, 0, 0);
        repeat (2) step();
        set_in(1, 0, 0, 1, 0);
        step();
        check_eq("bound_valid_on", bus.bound_valid, 1);
        check_eq("bound_sram9", bus.bound_sram, 9);
        check_eq("claim_req_off", bus.claim_req, 0);
        set_in(1, 1, 4, 0, 0);
        repeat (3) step();
        set_in(1, 0, 0, 0, 1);
        step();
        check_eq("released_sram", bus.bound_sram, N);

        // match_suc wins over match_enable dropping in the same cycle.
        set_in(1, 0, 0, 0, 0);
        repeat (2) step();
        set_in(0, 1, 5, 0, 0);
        step();
        check_eq("suc_priority", bus.claim_req, 1);
        set_in(0, 0, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0, 1);
        step();

        // Illegal pick is discarded.
        set_in(1, 0, 0, 0, 0);
        repeat (2) step();
        set_in(1, 1, 32, 0, 0);
        step();
        check_eq("illegal_no_req", bus.claim_req, 0);
        set_in(0, 0, 0, 0, 0);
        step();

        // Asynchronous reset while claiming.
        set_in(1, 0, 0, 0, 0);
        repeat (2) step();
        set_in(1, 1, 17, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0);
        async_reset();
        step();

`ifdef CLAIM_TIMEOUT_EN
        // Claim of SRAM31 never granted: fail pulse, then resume at 0.
        set_in(1, 0, 0, 0, 0);
        repeat (2) step();
        set_in(1, 1, 31, 0, 0);
        step();
        set_in(1, 0, 0, 0, 0);
        repeat (15) step();
        check_eq("no_fail_yet", bus.claim_fail, 0);
        step();
        check_eq("claim_fail_pulse", bus.claim_fail, 1);
        step();
        check_eq("resume_idx", bus.match_sram, 0);
        set_in(0, 0, 0, 0, 0);
        step();
`endif

        // Randomized traffic.
        random_status();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) random_status();
            bus.scan_offset = IW'($urandom_range(0, N - 1));
            set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                   $urandom_range(0, N + 1), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 299) == 0) async_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
